// File: rtl/slot_timer_pkg.sv
// Shared types and helpers for the round-robin slot timer arbiter.
package slot_timer_pkg;

  // Controller states: waiting for a request, counting a slot, one-cycle wrap-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W_DEFAULT   = 4;
  localparam int NUM_REQ_DEFAULT = 4;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic int unsigned onehot_idx(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/slot_timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_pick;

  // Circular index reduction; inputs stay below 2*NUM_REQ.
  function automatic logic [PW-1:0] wrap(input int unsigned a);
    return PW'(a % unsigned'(NUM_REQ));
  endfunction

  // Rotate so that rr_ptr lands on bit 0, then unrotate the winner back.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi]  = req[wrap(32'(gi) + 32'(rr_ptr))];
    assign pick[gi] = rot_pick[wrap(32'(gi) + 32'(NUM_REQ) - 32'(rr_ptr))];
  end

  // Isolate the lowest set bit of the rotated vector (priority encode).
  always_comb begin
    rot_pick = rot & (~rot + NUM_REQ'(1));
  end

  assign valid = |req;

endmodule

// File: rtl/slot_timer_arbiter.sv
// Round-robin owner of one shared slot timer; counts each owner's slot
// length and reports completion or early abort with one-cycle pulses.
module slot_timer_arbiter
  import slot_timer_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [CNT_W-1:0]         count,
  output logic [NUM_REQ-1:0]       done,
  output logic                     aborted
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_reg, state_next;
  logic [PW-1:0]      owner_reg, owner_next;
  logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   len_reg, len_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic               busy_reg, busy_next;
  logic               aborted_reg, aborted_next;

  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      ptr_after_owner;
  logic               owner_req;
  logic               at_end;
  logic [CNT_W-1:0]   lens [NUM_REQ];

  // Unpack the flat length bus into one entry per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
    assign lens[gi] = req_len[gi*CNT_W +: CNT_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .pick   (pick),
    .valid  (pick_valid)
  );

  assign pick_idx        = PW'(onehot_idx(32'(pick)));
  assign owner_req       = req[owner_reg];
  assign at_end          = (count_reg == len_reg);
  assign ptr_after_owner = (owner_reg == PW'(NUM_REQ - 1)) ? '0 : owner_reg + PW'(1);

  // State and registered outputs; reset clears everything including mid-slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      rr_ptr_reg  <= '0;
      len_reg     <= '0;
      count_reg   <= '0;
      grant_reg   <= '0;
      done_reg    <= '0;
      busy_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rr_ptr_reg  <= rr_ptr_next;
      len_reg     <= len_next;
      count_reg   <= count_next;
      grant_reg   <= grant_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      aborted_reg <= aborted_next;
    end
  end

  // Next-state: slot ends on owner drop or on reaching its length.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (pick_valid) state_next = RUN;
      RUN:     if (!owner_req || at_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of outputs and datapath; the abort test takes priority over
  // the length test, and count stops at len_reg so it never wraps.
  always_comb begin
    owner_next   = owner_reg;
    rr_ptr_next  = rr_ptr_reg;
    len_next     = len_reg;
    count_next   = '0;
    grant_next   = '0;
    done_next    = '0;
    aborted_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick;
          owner_next = pick_idx;
          len_next   = lens[pick_idx];
        end
      end
      RUN: begin
        if (!owner_req) begin
          aborted_next = 1'b1;
          rr_ptr_next  = ptr_after_owner;
        end else if (at_end) begin
          done_next[owner_reg] = 1'b1;
          rr_ptr_next          = ptr_after_owner;
        end else begin
          grant_next = grant_reg;
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
    busy_next = |grant_next;
  end

  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign count   = count_reg;
  assign done    = done_reg;
  assign aborted = aborted_reg;

`ifdef FORMAL
  // Structural invariants on the registered outputs.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(grant_reg));
      assert (busy_reg == (grant_reg != '0));
      assert (!((done_reg != '0) && aborted_reg));
      assert (((done_reg == '0) && !aborted_reg) || (state_reg == DONE));
      assert ($onehot0(done_reg));
      cover ((done_reg != '0) && (len_reg == '1));
      cover (aborted_reg);
    end
  end

  // Every requester can complete a slot.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cov
    always @(posedge clk) begin
      if (!rst) cover (done_reg[gi]);
    end
  end
`endif

endmodule

// File: tb/tb_slot_timer_arbiter.sv
// Scoreboard bench: each stimulus step queues the outputs expected on the
// following cycles; every cycle one entry is popped and compared.
module tb_slot_timer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic [CNT_W-1:0]   count;
    logic [NUM_REQ-1:0] done;
    logic               aborted;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*CNT_W-1:0] req_len = '0;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         count;
  logic [NUM_REQ-1:0]       done;
  logic                     aborted;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  slot_timer_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input int b, input int c, input int d, input int a);
    exp_t e;
    e.grant   = NUM_REQ'(g);
    e.busy    = 1'(b);
    e.count   = CNT_W'(c);
    e.done    = NUM_REQ'(d);
    e.aborted = 1'(a);
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    push(0, 0, 0, 0, 0);
  endtask

  // Running cycles of a slot owned by idx, counts first..first+n-1.
  task automatic push_run(input int idx, input int first, input int n);
    for (int k = 0; k < n; k++) push(1 << idx, 1, first + k, 0, 0);
  endtask

  // Full-length slot: len+1 running cycles then the done cycle.
  task automatic push_slot(input int idx, input int len);
    push_run(idx, 0, len + 1);
    push(0, 0, 0, 1 << idx, 0);
  endtask

  task automatic set_len(input int idx, input int v);
    req_len[idx*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic tick(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        check($sformatf("c%0d.q_empty", cyc), exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("c%0d.grant", cyc), grant, e.grant);
        check($sformatf("c%0d.busy", cyc), busy, e.busy);
        check($sformatf("c%0d.count", cyc), count, e.count);
        check($sformatf("c%0d.done", cyc), done, e.done);
        check($sformatf("c%0d.aborted", cyc), aborted, e.aborted);
        $display("cyc %0d req=%b grant=%b busy=%b count=%0d done=%b aborted=%b",
                 cyc, req, grant, busy, count, done, aborted);
      end
    end
  endtask

  initial begin
    // Reset state
    push_idle(); push_idle();
    tick(2);
    rst = 1'b0;

    // 1: single requester, length 3
    req = 4'b0001; set_len(0, 3);
    push_slot(0, 3);
    tick(5);
    req = 4'b0000;
    push_idle();
    tick(2 - 1);

    // Clean rr_ptr before the rotation check
    rst = 1'b1; push_idle(); tick(1); rst = 1'b0;

    // 2: all requesting, all length 0 -> rotation 0,1,2,3,0 with 3-cycle period
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 0);
    for (int s = 0; s < 5; s++) begin
      push_slot(s % NUM_REQ, 0);
      tick(2);
      if (s == 4) req = 4'b0000;
      push_idle();
      tick(1);
    end
    push_idle();
    tick(1);

    // 3: full-length slot, count reaches all-ones without wrapping
    req = 4'b0100; set_len(2, 15);
    push_slot(2, 15);
    tick(17);
    req = 4'b0000;
    push_idle();
    tick(1);

    // 4: owner 1 aborts at count 4; non-owner changes mid-slot ignored
    req = 4'b0010; set_len(1, 8); set_len(3, 2); set_len(0, 0);
    push_run(1, 0, 5);
    tick(2);
    req = 4'b1011;
    tick(3);
    req = 4'b1001;
    push(0, 0, 0, 0, 1);
    push_idle();
    tick(2);
    push_slot(3, 2);
    tick(4);
    req = 4'b0000;
    push_idle();
    tick(1);

    // Owner drops in the same cycle count reaches len: abort wins
    req = 4'b0001; set_len(0, 2);
    push_run(0, 0, 3);
    tick(3);
    req = 4'b0000;
    push(0, 0, 0, 0, 1);
    push_idle();
    tick(2);

    // 5: reset mid-slot at count 5 of length 10, then rr_ptr must be 0
    req = 4'b0100; set_len(2, 10);
    push_run(2, 0, 6);
    tick(6);
    rst = 1'b1;
    push_idle();
    tick(1);
    rst = 1'b0;
    req = 4'b1011; set_len(0, 0);
    push_slot(0, 0);
    tick(2);
    req = 4'b0000;
    push_idle();
    tick(1);

    // 6: length change mid-slot is ignored
    req = 4'b0001; set_len(0, 3);
    push_slot(0, 3);
    tick(2);
    set_len(0, 9);
    tick(3);
    req = 4'b0000;
    push_idle(); push_idle();
    tick(2);

    check("q_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got cyc=%0d expected completion", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
